// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared types and constants for the frame configuration loader
// Holds the loader state enum, the address-word field positions and the
// default sync/desync words.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  // Address word layout: [31:27] frame index, [26:20] column index, [19:0] unused
  localparam int FRAME_IDX_MSB = 31;
  localparam int FRAME_IDX_LSB = 27;
  localparam int COL_IDX_MSB   = 26;
  localparam int COL_IDX_LSB   = 20;
  localparam int FRAME_IDX_W   = FRAME_IDX_MSB - FRAME_IDX_LSB + 1;
  localparam int COL_IDX_W     = COL_IDX_MSB - COL_IDX_LSB + 1;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

endpackage

// File: rtl/frame_config_loader_if.sv
// rtl/frame_config_loader_if.sv - bitstream word stream handshake
// Signals: s_data (word), s_valid (word valid), s_ready (sink accepts).
// master: bitstream source; slave: the loader.
interface frame_config_loader_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/frame_cfg_onehot_dec.sv
// rtl/frame_cfg_onehot_dec.sv - binary index to one-hot decoder with enable
// Ports: idx (binary index), en (enable), onehot (WIDTH bits, all zero when
// disabled or when idx >= WIDTH).
module frame_cfg_onehot_dec #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  // Comparing per bit keeps out-of-range indices from selecting anything.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - writes bitstream frames into per-column frame latches
// Ports: CLK, resetn (async active-low); bs (bitstream stream, slave);
// FrameData (shared frame data), ColSelect (one-hot column), FrameStrobe
// (one-hot frame strobe), busy (not idle), err (sticky bad address),
// frames_written (saturating count of completed frame writes).
module frame_config_loader
  import frame_cfg_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 32,
  parameter logic [31:0] SyncWord        = SYNC_WORD,
  parameter logic [31:0] DesyncWord      = DESYNC_WORD
) (
  input  logic                       CLK,
  input  logic                       resetn,
  frame_config_loader_if.slave       bs,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [NumColumns-1:0]      ColSelect,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frames_written
);

  state_t                  state;
  logic                    ready_q;
  logic                    skip;
  logic [FRAME_IDX_W-1:0]  frame_idx;
  logic [COL_IDX_W-1:0]    col_idx;
  logic                    xfer;
  logic [FRAME_IDX_W-1:0]  in_frame;
  logic [COL_IDX_W-1:0]    in_col;
  logic                    bad_addr;
  logic [NumColumns-1:0]   col_onehot;
  logic [MaxFramesPerCol-1:0] frame_onehot;

  assign bs.s_ready = ready_q;
  assign xfer       = bs.s_valid && ready_q;
  assign in_frame   = bs.s_data[FRAME_IDX_MSB:FRAME_IDX_LSB];
  assign in_col     = bs.s_data[COL_IDX_MSB:COL_IDX_LSB];
  assign bad_addr   = (int'(in_frame) >= MaxFramesPerCol) || (int'(in_col) >= NumColumns);

  frame_cfg_onehot_dec #(.WIDTH(NumColumns), .IDX_W(COL_IDX_W)) u_col_dec (
    .idx    (col_idx),
    .en     (1'b1),
    .onehot (col_onehot)
  );

  // Enabled only during SETUP so the registered strobe is high for STROBE alone.
  frame_cfg_onehot_dec #(.WIDTH(MaxFramesPerCol), .IDX_W(FRAME_IDX_W)) u_frame_dec (
    .idx    (frame_idx),
    .en     (state == SETUP),
    .onehot (frame_onehot)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      ready_q        <= 1'b0;
      busy           <= 1'b0;
      skip           <= 1'b0;
      frame_idx      <= '0;
      col_idx        <= '0;
      FrameData      <= '0;
      ColSelect      <= '0;
      FrameStrobe    <= '0;
      err            <= 1'b0;
      frames_written <= '0;
    end else begin
      FrameStrobe <= frame_onehot;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (xfer && bs.s_data == SyncWord) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          if (xfer) begin
            if (bs.s_data == DesyncWord) begin
              state     <= IDLE;
              busy      <= 1'b0;
              ColSelect <= '0;
            end else begin
              // A bad address still consumes its data word, silently.
              frame_idx <= in_frame;
              col_idx   <= in_col;
              skip      <= bad_addr;
              if (bad_addr) err <= 1'b1;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (skip) begin
              skip  <= 1'b0;
              state <= ADDR;
            end else begin
              FrameData <= bs.s_data;
              ColSelect <= col_onehot;
              ready_q   <= 1'b0;
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
        end
        STROBE: begin
          state <= HOLD;
          if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
        end
        HOLD: begin
          state   <= ADDR;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
